// File: rtl/shiftadd_seq_reduce.sv
// shiftadd_seq_reduce
//   Sequential shift-add modular reducer. Computes x mod m for m = 2^k - 1 (Mersenne mode)
//   or m = 2^k + 1 (Fermat mode), with k chosen at run time. One k-bit segment is folded per
//   clock, so every legal k uses the same datapath.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset
//   start_i     operation request, honoured only while idle
//   mode_i      0 = Mersenne, 1 = Fermat
//   k_i         modulus bit parameter, legal range 2..DATA_W-1
//   x_i         unsigned operand
//   busy_o      high while folding
//   finish_o    one-cycle completion pulse
//   err_o       valid with finish_o, set when k_i was illegal
//   result_o    residue, held until the next finish_o
//   fold_cnt_o  fold count of the last operation, saturating at 255
module shiftadd_seq_reduce #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BL_W   = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [BL_W-1:0]   k_i,
    input  logic [DATA_W-1:0] x_i,
    output logic              busy_o,
    output logic              finish_o,
    output logic              err_o,
    output logic [DATA_W-1:0] result_o,
    output logic [7:0]        fold_cnt_o
);

    // Two guard bits: one for the Mersenne carry, one for the Fermat sign.
    localparam int unsigned AW = DATA_W + 2;

    typedef enum logic {StIdle, StFold} state_e;

    state_e               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 mode_q, mode_d;
    logic [BL_W-1:0]      k_q, k_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 ierr_q, ierr_d;
    logic                 busy_q;
    logic                 finish_q;
    logic                 err_q;
    logic [DATA_W-1:0]    result_q;
    logic [7:0]           fold_cnt_q;

    logic [AW-1:0]        pow_k;
    logic signed [AW-1:0] mask;
    logic signed [AW-1:0] lo;
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] fold_val;
    logic                 fold_done;
    logic                 k_legal;
    logic                 accept;
    logic [DATA_W-1:0]    res_val;

    assign pow_k    = AW'(1) << k_q;
    assign mask     = $signed(pow_k - AW'(1));
    assign lo       = acc_q & mask;
    assign hi       = acc_q >>> k_q;
    // 2^k == 1 mod (2^k-1) and 2^k == -1 mod (2^k+1).
    assign fold_val = mode_q ? (lo - hi) : (lo + hi);
    // Fermat accepts 2^k itself as a residue so acc = 2^k never loops.
    assign fold_done = mode_q ? (!acc_q[AW-1] && (acc_q <= $signed(pow_k)))
                              : (hi == '0);

    assign k_legal = (k_i >= BL_W'(2)) && (k_i <= BL_W'(DATA_W - 1));
    // busy_q still high on the cycle after the done decision; block starts until it drops.
    assign accept  = start_i && (state_q == StIdle) && !busy_q;

    // acc, mode and k are frozen after the done decision, so the residue is read one cycle later.
    assign res_val = (!mode_q && (acc_q == mask)) ? '0 : acc_q[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ierr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (k_legal) begin
                        state_d = StFold;
                        acc_d   = $signed({2'b00, x_i});
                        mode_d  = mode_i;
                        k_d     = k_i;
                        cnt_d   = '0;
                    end else begin
                        ierr_d = 1'b1;
                    end
                end
            end
            StFold: begin
                if (fold_done) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    acc_d = fold_val;
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            k_q        <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ierr_q     <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            fold_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mode_q   <= mode_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ierr_q   <= ierr_d;
            busy_q   <= (state_q == StFold);
            // done_q and ierr_q are never high together: ierr needs an idle, non-busy FSM.
            finish_q <= done_q | ierr_q;
            if (done_q) begin
                result_q   <= res_val;
                fold_cnt_q <= cnt_q;
                err_q      <= 1'b0;
            end else if (ierr_q) begin
                result_q   <= '0;
                fold_cnt_q <= '0;
                err_q      <= 1'b1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign finish_o   = finish_q;
    assign err_o      = err_q;
    assign result_o   = result_q;
    assign fold_cnt_o = fold_cnt_q;

endmodule
